// File: rtl/comma_aligner_10b_if.sv
// Symbol/handshake bundle between the 8:10 gearbox side and the comma aligner.
interface comma_aligner_10b_if;
  logic       ser_valid;
  logic       sym_valid;
  logic [9:0] sym;
  logic       bitslip;
  logic       dout_valid;
  logic [9:0] dout;
  logic       dout_comma;
  logic       locked;

  // Gearbox / upstream side: supplies symbols, consumes slips and aligned data.
  modport master (
    output ser_valid, sym_valid, sym,
    input  bitslip, dout_valid, dout, dout_comma, locked
  );

  // Aligner side.
  modport slave (
    input  ser_valid, sym_valid, sym,
    output bitslip, dout_valid, dout, dout_comma, locked
  );
endinterface

// File: rtl/comma_aligner_10b.sv
// K28.5 comma aligner: finds the bit offset of misaligned commas in the
// gearbox symbol stream, slips the gearbox until commas sit on the symbol
// boundary, and reports lock. Symbols pass through with one cycle of latency.
module comma_aligner_10b #(
  parameter int LOCK_COMMAS  = 4,
  parameter int MAX_GAP      = 1023,
  parameter int ERR_LIMIT    = 3,
  parameter int SETTLE_WORDS = 4
) (
  input logic                clk,
  input logic                rst_n,
  comma_aligner_10b_if.slave bus
);

  localparam int GAP_W = $clog2(MAX_GAP + 2);
  localparam int CNT_W = $clog2(LOCK_COMMAS + 1);
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);
  localparam int SET_W = $clog2(SETTLE_WORDS + 1);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SLIP,
    ST_SETTLE,
    ST_VERIFY,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       slips_left_q, slips_left_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;

  // Only the low 9 bits of the previous symbol can take part in a k=1..9
  // window, so bit 9 is not kept.
  logic [8:0]       prev_sym_q, prev_sym_d;
  logic [9:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_comma_q, dout_comma_d;

  logic [18:0]      win;
  logic             aligned_hit;
  logic             mis_hit;
  logic [3:0]       mis_k;
  logic             bitslip;

  function automatic logic is_comma(input logic [6:0] p);
    return (p == 7'b0011111) || (p == 7'b1100000);
  endfunction

  // Comma detection: aligned window plus the lowest misaligned offset k.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win         = {prev_sym_q, bus.sym};
    aligned_hit = bus.sym_valid && is_comma(bus.sym[9:3]);
    mis_hit     = 1'b0;
    mis_k       = 4'd0;
    // Scan downwards so the last hit written is the lowest k.
    for (int k = 9; k >= 1; k--) begin
      if (is_comma(win[3+k +: 7])) begin
        mis_hit = bus.sym_valid;
        mis_k   = 4'(k);
      end
    end
    gap_inc = (&gap_q) ? gap_q : gap_q + GAP_W'(1);
  end

  // Datapath next values; passes symbols through regardless of state.
  always_comb begin
    dout_valid_d = bus.sym_valid;
    dout_d       = bus.sym_valid ? bus.sym      : dout_q;
    dout_comma_d = bus.sym_valid ? aligned_hit  : dout_comma_q;
    prev_sym_d   = bus.sym_valid ? bus.sym[8:0] : prev_sym_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_comma_q <= 1'b0;
      prev_sym_q   <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_comma_q <= dout_comma_d;
      prev_sym_q   <= prev_sym_d;
    end
  end

  // FSM state register and its counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      slips_left_q <= '0;
      settle_q     <= '0;
      comma_cnt_q  <= '0;
      err_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      slips_left_q <= slips_left_d;
      settle_q     <= settle_d;
      comma_cnt_q  <= comma_cnt_d;
      err_q        <= err_d;
      gap_q        <= gap_d;
    end
  end

  // FSM next state: hunt, slip, settle, verify, locked.
  always_comb begin
    state_d      = state_q;
    slips_left_d = slips_left_q;
    settle_d     = settle_q;
    comma_cnt_d  = comma_cnt_q;
    err_d        = err_q;
    gap_d        = gap_q;
    // gap counts valid symbols since the last aligned comma.
    if (bus.sym_valid) gap_d = aligned_hit ? '0 : gap_inc;

    unique case (state_q)
      ST_HUNT: begin
        if (aligned_hit) begin
          comma_cnt_d = CNT_W'(1);
          state_d     = ST_VERIFY;
        end else if (mis_hit) begin
          slips_left_d = 4'd10 - mis_k;
          state_d      = ST_SLIP;
        end
      end
      ST_SLIP: begin
        if (slips_left_q == '0) begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else if (bitslip) begin
          slips_left_d = slips_left_q - 4'd1;
          if (slips_left_q == 4'd1) begin
            settle_d = '0;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        // Symbols straight after a slip burst may be torn; ignore them.
        if (bus.sym_valid) begin
          settle_d = settle_q + SET_W'(1);
          if (settle_q == SET_W'(SETTLE_WORDS - 1)) state_d = ST_HUNT;
        end
      end
      ST_VERIFY: begin
        if (aligned_hit) begin
          comma_cnt_d = comma_cnt_q + CNT_W'(1);
          if (comma_cnt_q == CNT_W'(LOCK_COMMAS - 1)) begin
            err_d   = '0;
            state_d = ST_LOCKED;
          end
        end else if (mis_hit) begin
          state_d = ST_HUNT;
        end else if (gap_q > GAP_W'(MAX_GAP)) begin
          state_d = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        if (aligned_hit) begin
          err_d = '0;
        end else if (mis_hit || (bus.sym_valid && gap_inc == GAP_W'(MAX_GAP))) begin
          gap_d = '0;
          err_d = err_q + ERR_W'(1);
          if (err_q == ERR_W'(ERR_LIMIT - 1)) begin
            err_d   = '0;
            state_d = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // FSM outputs: slip only when the gearbox will sample it.
  always_comb begin
    bitslip    = (state_q == ST_SLIP) && (slips_left_q != '0) && bus.ser_valid && rst_n;
    bus.bitslip = bitslip;
    bus.locked  = (state_q == ST_LOCKED);
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.dout_comma = dout_comma_q;

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Bench for comma_aligner_10b: directed tables, gearbox-driven alignment
// scenarios and randomized traffic, all compared to a behavioural model.
module tb_comma_aligner_10b;

  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;
  localparam logic [9:0] D_215 = 10'b1010101010;
  localparam logic [9:0] MIS1  = 10'b0111110101;  // k=1 comma after a word ending in 0

  localparam int M_HUNT = 0, M_SLIP = 1, M_SETTLE = 2, M_VERIFY = 3, M_LOCKED = 4;
  localparam int GAP_SAT = (1 << $clog2(1023 + 2)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comma_aligner_10b_if bus();

  comma_aligner_10b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int slip_cnt = 0;
  int bare_slips = 0;
  int gb_ptr = 0;
  logic last_bs = 1'b0;

  // Reference model state (spec-level quantities)
  int         m_mode, m_left, m_settle, m_cnt, m_err, m_gap;
  logic [9:0] m_prev, m_dout;
  logic       m_dv, m_comma;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Returns 0 for an aligned comma, k (1..9) for the lowest misaligned one, -1 for none.
  function automatic int find_k(input logic [9:0] p, input logic [9:0] s);
    logic [19:0] w;
    logic [6:0]  pat;
    w = {p, s};
    for (int k = 0; k < 10; k++) begin
      pat = 7'(w >> (3 + k));
      if (pat == 7'b0011111 || pat == 7'b1100000) return k;
    end
    return -1;
  endfunction

  function automatic logic exp_bitslip(input logic rst, input logic ser_v);
    return rst && ser_v && (m_mode == M_SLIP) && (m_left != 0);
  endfunction

  task automatic model_edge(input logic rst, input logic ser_v, input logic sym_v,
                            input logic [9:0] s);
    int   k;
    int   gap_before;
    logic bs;
    if (!rst) begin
      m_mode = M_HUNT; m_left = 0; m_settle = 0; m_cnt = 0; m_err = 0; m_gap = 0;
      m_prev = '0; m_dout = '0; m_dv = 1'b0; m_comma = 1'b0;
      return;
    end
    k  = sym_v ? find_k(m_prev, s) : -1;
    bs = exp_bitslip(rst, ser_v);
    m_dv = sym_v;
    if (sym_v) begin
      m_dout  = s;
      m_comma = (k == 0);
      m_prev  = s;
    end
    gap_before = m_gap;
    if (sym_v) m_gap = (k == 0) ? 0 : ((m_gap < GAP_SAT) ? m_gap + 1 : GAP_SAT);
    case (m_mode)
      M_HUNT:
        if (k == 0) begin m_cnt = 1; m_mode = M_VERIFY; end
        else if (k > 0) begin m_left = 10 - k; m_mode = M_SLIP; end
      M_SLIP:
        if (m_left == 0) begin m_settle = 0; m_mode = M_SETTLE; end
        else if (bs) begin
          m_left--;
          if (m_left == 0) begin m_settle = 0; m_mode = M_SETTLE; end
        end
      M_SETTLE:
        if (sym_v) begin
          m_settle++;
          if (m_settle == 4) m_mode = M_HUNT;
        end
      M_VERIFY:
        if (k == 0) begin
          m_cnt++;
          if (m_cnt == 4) begin m_err = 0; m_mode = M_LOCKED; end
        end else if (k > 0) m_mode = M_HUNT;
        else if (gap_before > 1023) m_mode = M_HUNT;
      M_LOCKED:
        if (k == 0) m_err = 0;
        else if (sym_v && (k > 0 || m_gap == 1023)) begin
          m_gap = 0;
          m_err++;
          if (m_err == 3) begin m_err = 0; m_mode = M_HUNT; end
        end
      default: m_mode = M_HUNT;
    endcase
  endtask

  // One clock: drive inputs, check combinational bitslip, then registered outputs.
  task automatic tick(input logic ser_v, input logic sym_v, input logic [9:0] s);
    logic exp_bs;
    bus.ser_valid = ser_v;
    bus.sym_valid = sym_v;
    bus.sym       = s;
    #1;
    exp_bs = exp_bitslip(rst_n, ser_v);
    check("bitslip", {31'd0, bus.bitslip}, {31'd0, exp_bs});
    last_bs = bus.bitslip;
    if (bus.bitslip) begin
      slip_cnt++;
      if (!ser_v) bare_slips++;
    end
    model_edge(rst_n, ser_v, sym_v, s);
    @(posedge clk);
    #1;
    check("outputs{locked,dv,comma,dout}",
          {19'd0, bus.locked, bus.dout_valid, bus.dout_comma, bus.dout},
          {19'd0, logic'(m_mode == M_LOCKED), m_dv, m_comma, m_dout});
  endtask

  // Gearbox stream: period of 8 symbols (one K28.5, seven D21.5); bitslip drops one bit.
  function automatic logic [9:0] gb_sym(input int p);
    logic [9:0] s;
    logic [9:0] word;
    int         i;
    s = '0;
    for (int b = 0; b < 10; b++) begin
      i = p + b;
      word = ((i / 10) % 8 == 0) ? K_RDN : D_215;
      s[9-b] = word[9 - (i % 10)];
    end
    return s;
  endfunction

  task automatic gb_tick(input logic ser_v, input logic sym_v);
    tick(ser_v, sym_v, sym_v ? gb_sym(gb_ptr) : 10'h000);
    if (sym_v) gb_ptr += 10;
    if (last_bs) gb_ptr += 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 10'h000);
    tick(1'b1, 1'b1, D_215);
    rst_n = 1'b1;
    check("reset_state", {19'd0, bus.locked, bus.dout_valid, bus.dout_comma, bus.dout}, 32'd0);
  endtask

  typedef struct {
    logic       sv;
    logic [9:0] sym;
    logic       dv;
    logic [9:0] dout;
    logic       comma;
    logic       lk;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ser_valid = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym       = '0;
    model_edge(1'b0, 1'b0, 1'b0, 10'h000);
    @(posedge clk);
    #1;

    // Detection table from reset: both comma polarities, hold on !sym_valid,
    // k=10 window excluded, k=1 misaligned comma while locked.
    tbl[0] = '{1'b1, K_RDN,         1'b1, K_RDN,         1'b1, 1'b0};
    tbl[1] = '{1'b0, D_215,         1'b0, K_RDN,         1'b1, 1'b0};
    tbl[2] = '{1'b1, D_215,         1'b1, D_215,         1'b0, 1'b0};
    tbl[3] = '{1'b1, K_RDP,         1'b1, K_RDP,         1'b1, 1'b0};
    tbl[4] = '{1'b1, D_215,         1'b1, D_215,         1'b0, 1'b0};
    tbl[5] = '{1'b1, 10'b0011111111, 1'b1, 10'b0011111111, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 10'b1100000000, 1'b1, 10'b1100000000, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 10'b0000000000, 1'b1, 10'b0000000000, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 10'b0111110000, 1'b1, 10'b0111110000, 1'b0, 1'b1};
    tbl[9] = '{1'b1, D_215,         1'b1, D_215,         1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, tbl[i].sv, tbl[i].sym);
      check($sformatf("table[%0d]", i),
            {19'd0, bus.locked, bus.dout_valid, bus.dout_comma, bus.dout},
            {19'd0, tbl[i].lk, tbl[i].dv, tbl[i].comma, tbl[i].dout});
    end

    // 1: aligned stream, lock on the 4th comma, no slips
    do_reset();
    gb_ptr = 0; slip_cnt = 0;
    for (int n = 0; n < 24; n++) gb_tick(1'b1, 1'b1);
    check("t1_locked_before_4th", {31'd0, bus.locked}, 32'd0);
    check("t1_comma_on_data", {31'd0, bus.dout_comma}, 32'd0);
    gb_tick(1'b1, 1'b1);
    check("t1_locked_at_4th", {31'd0, bus.locked}, 32'd1);
    check("t1_comma_flag", {21'd0, bus.dout_comma, bus.dout}, {21'd0, 1'b1, K_RDN});
    check("t1_no_slips", slip_cnt, 0);

    // 2: comma at k=3 -> 7 slips, settle, lock
    do_reset();
    gb_ptr = 3; slip_cnt = 0; bare_slips = 0;
    for (int n = 0; n < 400 && !bus.locked; n++) gb_tick(1'b1, 1'b1);
    check("t2_slip_count", slip_cnt, 7);
    check("t2_locked", {31'd0, bus.locked}, 32'd1);

    // 3: sparse ser_valid during the slip burst
    do_reset();
    gb_ptr = 3; slip_cnt = 0; bare_slips = 0;
    for (int n = 0; n < 600 && !bus.locked; n++) gb_tick(logic'(n % 3 == 0), 1'b1);
    check("t3_slip_count", slip_cnt, 7);
    check("t3_bare_slips", bare_slips, 0);
    check("t3_locked", {31'd0, bus.locked}, 32'd1);

    // 4: comma starvation while locked; third gap event drops lock
    for (int n = 0; n < 20 && (gb_ptr % 80) != 10; n++) gb_tick(1'b1, 1'b1);
    check("t4_start_on_comma", {31'd0, bus.dout_comma}, 32'd1);
    for (int n = 0; n < 3068; n++) tick(1'b1, 1'b1, D_215);
    check("t4_locked_before_3rd_gap", {31'd0, bus.locked}, 32'd1);
    tick(1'b1, 1'b1, D_215);
    check("t4_unlocked_at_3rd_gap", {31'd0, bus.locked}, 32'd0);
    for (int n = 0; n < 3; n++) tick(1'b1, 1'b1, D_215);
    for (int n = 0; n < 200 && !bus.locked; n++) gb_tick(1'b1, 1'b1);
    check("t4_relocked", {31'd0, bus.locked}, 32'd1);
    tick(1'b1, 1'b1, D_215);
    tick(1'b1, 1'b1, MIS1);
    check("t4_single_mis_keeps_lock", {31'd0, bus.locked}, 32'd1);
    tick(1'b1, 1'b1, D_215);
    tick(1'b1, 1'b1, MIS1);
    check("t4_second_mis_keeps_lock", {31'd0, bus.locked}, 32'd1);
    tick(1'b1, 1'b1, D_215);
    tick(1'b1, 1'b1, MIS1);
    check("t4_err_limit_drops_lock", {31'd0, bus.locked}, 32'd0);

    // 5: reset in the middle of a slip burst
    do_reset();
    gb_ptr = 3; slip_cnt = 0;
    for (int n = 0; n < 100 && slip_cnt < 3; n++) gb_tick(1'b1, 1'b1);
    check("t5_mid_burst", slip_cnt, 3);
    rst_n = 1'b0;
    gb_tick(1'b1, 1'b1);
    check("t5_bitslip_in_reset", {31'd0, last_bs}, 32'd0);
    check("t5_outputs_reset",
          {19'd0, bus.locked, bus.dout_valid, bus.dout_comma, bus.dout}, 32'd0);
    gb_tick(1'b1, 1'b1);
    rst_n = 1'b1;
    for (int n = 0; n < 400 && !bus.locked; n++) gb_tick(1'b1, 1'b1);
    check("t5_relocked", {31'd0, bus.locked}, 32'd1);

    // Random: gearbox offsets with random valids
    for (int r = 0; r < 6; r++) begin
      do_reset();
      gb_ptr = int'($urandom_range(0, 9));
      for (int n = 0; n < 300; n++)
        gb_tick(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0));
    end

    // Random: raw symbol mix with occasional resets
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [9:0] s;
      case ($urandom_range(0, 3))
        0:       s = K_RDN;
        1:       s = K_RDP;
        2:       s = D_215;
        default: s = 10'($urandom);
      endcase
      rst_n = logic'($urandom_range(0, 299) != 0);
      tick(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0), s);
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
